dyt_rf_write_arbiter: RTL and testbench
=======================================

DYT_RF_WRITE_ARBITER -- requirements
Module: dyt_rf_write_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: wb_req  in  1  writeback-stage write request.
REQ-004 SHALL have ports: wb_sel  in  rf_addr_t  writeback destination register.
REQ-005 SHALL have ports: wb_data  in  word_t  writeback write data.
REQ-006 SHALL have ports: wb_gnt  out  1  writeback request accepted this cycle.
REQ-007 SHALL have ports: mc_req  in  1  multi-cycle unit (load/mul/div) write request.
REQ-008 SHALL have ports: mc_sel  in  rf_addr_t  multi-cycle destination register.
REQ-009 SHALL have ports: mc_data  in  word_t  multi-cycle write data.
REQ-010 SHALL have ports: mc_gnt  out  1  multi-cycle request accepted this cycle.
REQ-011 SHALL have ports: rd_sel_0, rd_sel_1  in  rf_addr_t  CPU read selects.
REQ-012 SHALL have ports: rd_data_0, rd_data_1  out  word_t  forwarded read data to CPU.
REQ-013 SHALL have ports: rf_wen, rf_w_sel, rf_w_data, rf_r_sel_0, rf_r_sel_1  out  1/rf_addr_t/word_t  register-file-side signals (cpu modport directions).
REQ-014 SHALL have ports: rf_r_data_0, rf_r_data_1  in  word_t  raw register file read data.

Function
REQ-015 SHALL assert at most one of wb_gnt/mc_gnt per cycle, combinationally in the cycle its req is high; gnt never high without its req.
REQ-016 SHALL hold a one-bit last-winner pointer; when both req high, grant the requester not granted most recently, then update pointer to the winner.
REQ-017 SHALL, when only one req is high, grant it immediately regardless of pointer; pointer updates to that winner.
REQ-018 SHALL require requesters to hold req/sel/data stable until gnt; dropping req before gnt is legal and cancels the request.
REQ-019 SHALL register the granted sel/data into a write stage; rf_wen/rf_w_sel/rf_w_data driven from it exactly 1 cycle after gnt.
REQ-020 SHALL treat a granted write with sel == 0 as accepted (gnt high) but produce rf_wen = 0 next cycle.
REQ-021 SHALL drive rf_r_sel_0/1 = rd_sel_0/1 combinationally.
REQ-022 SHALL forward: rd_data_x = rf_w_data when rf_wen && rf_w_sel == rd_sel_x && rd_sel_x != 0, else rf_r_data_x.
REQ-023 SHALL sustain one accepted write per cycle, back-to-back, no bubbles.
REQ-024 SHALL, with no grant in a cycle, drive rf_wen = 0 the following cycle.

Reset
REQ-025 SHALL on rst clear write stage: rf_wen = 0, rf_w_sel = 0, rf_w_data = 0; pointer = mc (so wb wins first tie).
REQ-026 SHALL force wb_gnt = mc_gnt = 0 while rst high; a write in the write stage when rst rises SHALL be discarded (rf_wen = 0 next cycle).

Configuration
REQ-027 SHALL honour macro DYT_RF_ARB_ROUND_ROBIN_EN: defined -> round-robin per REQ-016; undefined -> fixed priority, wb always wins ties, pointer logic removed.

Structure
REQ-028 SHALL take word_t, rf_addr_t from common_types; add to common_types: arb_src_t enum (ARB_SRC_WB, ARB_SRC_MC) and RF_ZERO_REG constant.
REQ-029 SHALL contain one sub-module, dyt_rr_arbiter_2 (two-input arbiter with pointer), instantiated once.

Verification
REQ-030 SHALL cover: wb_req only, sel=5, data=0xDEADBEEF -> wb_gnt same cycle; next cycle rf_wen=1, rf_w_sel=5, rf_w_data=0xDEADBEEF.
REQ-031 SHALL cover: both req held 4 cycles after reset (sel 3/4) -> grants wb,mc,wb,mc (RR); macro off -> wb every cycle, mc_gnt=0.
REQ-032 SHALL cover: mc write sel=0, data=0x1234 -> mc_gnt=1, next cycle rf_wen=0; rd_sel_0=0 returns rf_r_data_0.
REQ-033 SHALL cover: write sel=7 data=0xA5A5A5A5 granted, next cycle rd_sel_1=7 with rf_r_data_1=0 -> rd_data_1=0xA5A5A5A5.
REQ-034 SHALL cover: rst asserted the cycle after a grant -> rf_wen=0, both gnt=0 during rst; first tie after rst goes to wb.

Source files
------------

// File: rtl/common_types.sv
// Shared scalar types for the register-file write path: word/address types,
// write-source encoding and the hard-wired zero register index.
package common_types;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned RF_ADDR_W = 5;

    typedef logic [XLEN-1:0]      word_t;
    typedef logic [RF_ADDR_W-1:0] rf_addr_t;

    typedef enum logic {
        ARB_SRC_WB = 1'b0,
        ARB_SRC_MC = 1'b1
    } arb_src_t;

    localparam rf_addr_t RF_ZERO_REG = '0;

endpackage

// File: rtl/dyt_rf_write_arbiter_if.sv
// Bundle of requester handshakes, CPU read port and register-file side signals.
// master = requesters/CPU/register file, slave = the write arbiter.
interface dyt_rf_write_arbiter_if;
    import common_types::*;

    logic     wb_req;
    rf_addr_t wb_sel;
    word_t    wb_data;
    logic     wb_gnt;

    logic     mc_req;
    rf_addr_t mc_sel;
    word_t    mc_data;
    logic     mc_gnt;

    rf_addr_t rd_sel_0;
    rf_addr_t rd_sel_1;
    word_t    rd_data_0;
    word_t    rd_data_1;

    logic     rf_wen;
    rf_addr_t rf_w_sel;
    word_t    rf_w_data;
    rf_addr_t rf_r_sel_0;
    rf_addr_t rf_r_sel_1;
    word_t    rf_r_data_0;
    word_t    rf_r_data_1;

    modport master (
        output wb_req, wb_sel, wb_data, mc_req, mc_sel, mc_data,
        output rd_sel_0, rd_sel_1, rf_r_data_0, rf_r_data_1,
        input  wb_gnt, mc_gnt, rd_data_0, rd_data_1,
        input  rf_wen, rf_w_sel, rf_w_data, rf_r_sel_0, rf_r_sel_1
    );

    modport slave (
        input  wb_req, wb_sel, wb_data, mc_req, mc_sel, mc_data,
        input  rd_sel_0, rd_sel_1, rf_r_data_0, rf_r_data_1,
        output wb_gnt, mc_gnt, rd_data_0, rd_data_1,
        output rf_wen, rf_w_sel, rf_w_data, rf_r_sel_0, rf_r_sel_1
    );

endinterface

// File: rtl/dyt_rr_arbiter_2.sv
// Two-input combinational arbiter. With DYT_RF_ARB_ROUND_ROBIN_EN defined a
// last-winner pointer breaks ties; otherwise input 0 always wins ties.
module dyt_rr_arbiter_2
    import common_types::*;
(
`ifdef DYT_RF_ARB_ROUND_ROBIN_EN
    input  logic clk,
    input  logic rst,
`endif
    input  logic req_0,
    input  logic req_1,
    output logic gnt_0,
    output logic gnt_1
);

`ifdef DYT_RF_ARB_ROUND_ROBIN_EN
    arb_src_t last_q;

    always_comb begin
        gnt_0 = 1'b0;
        gnt_1 = 1'b0;
        if (req_0 && req_1) begin
            if (last_q == ARB_SRC_MC) gnt_0 = 1'b1;
            else                      gnt_1 = 1'b1;
        end else begin
            gnt_0 = req_0;
            gnt_1 = req_1;
        end
    end

    // Reset to the mc side so the first tie goes to wb.
    always_ff @(posedge clk) begin
        if (rst)        last_q <= ARB_SRC_MC;
        else if (gnt_0) last_q <= ARB_SRC_WB;
        else if (gnt_1) last_q <= ARB_SRC_MC;
    end
`else
    always_comb begin
        gnt_0 = req_0;
        gnt_1 = req_1 & ~req_0;
    end
`endif

endmodule

// File: rtl/dyt_rf_write_arbiter.sv
// Arbitrates writeback and multi-cycle writes into one register-file write
// port with a one-cycle write stage and read forwarding. Tie policy selected
// by DYT_RF_ARB_ROUND_ROBIN_EN (round-robin) else fixed wb priority.
module dyt_rf_write_arbiter
    import common_types::*;
(
    input  logic                  clk,
    input  logic                  rst,
    dyt_rf_write_arbiter_if.slave bus
);

    logic     req_wb;
    logic     req_mc;
    logic     gnt_wb;
    logic     gnt_mc;
    arb_src_t src;
    rf_addr_t sel_nxt;
    word_t    data_nxt;

    logic     wen_q;
    rf_addr_t sel_q;
    word_t    data_q;

    // Gating requests with rst keeps both grants low during reset.
    assign req_wb = bus.wb_req & ~rst;
    assign req_mc = bus.mc_req & ~rst;

    dyt_rr_arbiter_2 u_arb (
`ifdef DYT_RF_ARB_ROUND_ROBIN_EN
        .clk   (clk),
        .rst   (rst),
`endif
        .req_0 (req_wb),
        .req_1 (req_mc),
        .gnt_0 (gnt_wb),
        .gnt_1 (gnt_mc)
    );

    always_comb begin
        src      = gnt_mc ? ARB_SRC_MC : ARB_SRC_WB;
        sel_nxt  = (src == ARB_SRC_MC) ? bus.mc_sel  : bus.wb_sel;
        data_nxt = (src == ARB_SRC_MC) ? bus.mc_data : bus.wb_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q  <= 1'b0;
            sel_q  <= '0;
            data_q <= '0;
        end else if (gnt_wb || gnt_mc) begin
            wen_q  <= (sel_nxt != RF_ZERO_REG);
            sel_q  <= sel_nxt;
            data_q <= data_nxt;
        end else begin
            wen_q  <= 1'b0;
        end
    end

    assign bus.wb_gnt     = gnt_wb;
    assign bus.mc_gnt     = gnt_mc;
    assign bus.rf_wen     = wen_q;
    assign bus.rf_w_sel   = sel_q;
    assign bus.rf_w_data  = data_q;
    assign bus.rf_r_sel_0 = bus.rd_sel_0;
    assign bus.rf_r_sel_1 = bus.rd_sel_1;

    assign bus.rd_data_0 = (wen_q && sel_q == bus.rd_sel_0 && bus.rd_sel_0 != RF_ZERO_REG)
                           ? data_q : bus.rf_r_data_0;
    assign bus.rd_data_1 = (wen_q && sel_q == bus.rd_sel_1 && bus.rd_sel_1 != RF_ZERO_REG)
                           ? data_q : bus.rf_r_data_1;

endmodule

// File: tb/tb_dyt_rf_write_arbiter.sv
// Scoreboard bench for dyt_rf_write_arbiter: expected write-stage contents are
// queued at each grant and compared one cycle later, grants checked per cycle.
module tb_dyt_rf_write_arbiter;
    import common_types::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dyt_rf_write_arbiter_if bus ();

    dyt_rf_write_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic     wen;
        rf_addr_t sel;
        word_t    data;
        logic     full;
    } ws_t;

    ws_t         sb_q[$];
    int unsigned n_chk = 0;
    int unsigned n_pass = 0;
    logic        model_last = 1'b1;  // 1 = mc won last
    logic        eg_wb_last = 1'b0;
    logic        eg_mc_last = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step(input logic r,
                        input logic wr, input rf_addr_t ws, input word_t wd,
                        input logic mr, input rf_addr_t ms, input word_t md,
                        input rf_addr_t s0, input rf_addr_t s1,
                        input word_t d0, input word_t d1);
        logic eg_wb, eg_mc;
        ws_t  cur;
        word_t e0, e1;
        rst             = r;
        bus.wb_req      = wr;  bus.wb_sel = ws;  bus.wb_data = wd;
        bus.mc_req      = mr;  bus.mc_sel = ms;  bus.mc_data = md;
        bus.rd_sel_0    = s0;  bus.rd_sel_1 = s1;
        bus.rf_r_data_0 = d0;  bus.rf_r_data_1 = d1;
        @(negedge clk);
        eg_wb = 1'b0;
        eg_mc = 1'b0;
        if (!r) begin
            if (wr && mr) begin
`ifdef DYT_RF_ARB_ROUND_ROBIN_EN
                if (model_last) eg_wb = 1'b1;
                else            eg_mc = 1'b1;
`else
                eg_wb = 1'b1;
`endif
            end else begin
                eg_wb = wr;
                eg_mc = mr;
            end
        end
        check("wb_gnt", 32'(bus.wb_gnt), 32'(eg_wb));
        check("mc_gnt", 32'(bus.mc_gnt), 32'(eg_mc));
        check("rf_r_sel_0", 32'(bus.rf_r_sel_0), 32'(s0));
        check("rf_r_sel_1", 32'(bus.rf_r_sel_1), 32'(s1));
        if (sb_q.size() > 0) begin
            cur = sb_q.pop_front();
            check("rf_wen", 32'(bus.rf_wen), 32'(cur.wen));
            if (cur.wen || cur.full) begin
                check("rf_w_sel", 32'(bus.rf_w_sel), 32'(cur.sel));
                check("rf_w_data", bus.rf_w_data, cur.data);
            end
            e0 = (cur.wen && cur.sel == s0 && s0 != 0) ? cur.data : d0;
            e1 = (cur.wen && cur.sel == s1 && s1 != 0) ? cur.data : d1;
            check("rd_data_0", bus.rd_data_0, e0);
            check("rd_data_1", bus.rd_data_1, e1);
        end
        if (r)          sb_q.push_back('{wen: 1'b0, sel: '0, data: '0, full: 1'b1});
        else if (eg_wb) sb_q.push_back('{wen: (ws != 0), sel: ws, data: wd, full: 1'b0});
        else if (eg_mc) sb_q.push_back('{wen: (ms != 0), sel: ms, data: md, full: 1'b0});
        else            sb_q.push_back('{wen: 1'b0, sel: '0, data: '0, full: 1'b0});
        if (r)          model_last = 1'b1;
        else if (eg_wb) model_last = 1'b0;
        else if (eg_mc) model_last = 1'b1;
        eg_wb_last = eg_wb;
        eg_mc_last = eg_mc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic     wr, mr;
        rf_addr_t ws, ms;
        word_t    wd, md;
        // Reset with both requests high: grants must stay low.
        step(1, 1, 5'd1, 32'h1, 1, 5'd2, 32'h2, 0, 0, 32'h0, 32'h0);
        step(1, 1, 5'd1, 32'h1, 1, 5'd2, 32'h2, 0, 0, 32'h0, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 5'd3, 5'd4, 32'h33, 32'h44);
        // Single wb write, then forward it on both read ports.
        step(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 5'd5, 5'd5, 32'h11, 32'h22);
        step(0, 0, 0, 0, 0, 0, 0, 5'd5, 5'd6, 32'h11, 32'h22);
        // Fresh reset then a 4-cycle tie.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++)
            step(0, 1, 5'd3, 32'h300 + i, 1, 5'd4, 32'h400 + i, 5'd3, 5'd4, 32'hA, 32'hB);
        step(0, 0, 0, 0, 0, 0, 0, 5'd3, 5'd4, 32'hA, 32'hB);
        // mc write to the zero register: accepted, no write enable.
        step(0, 0, 0, 0, 1, 5'd0, 32'h1234, 0, 0, 32'h0, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 32'h55, 32'h66);
        // Write r7, read it back through port 1 with raw data zero.
        step(0, 1, 5'd7, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 5'd1, 5'd7, 32'h77, 32'h0);
        // Grant followed immediately by reset; first tie afterwards.
        step(0, 1, 5'd9, 32'hCAFE0009, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        step(1, 1, 5'd9, 32'h1, 1, 5'd10, 32'h2, 5'd9, 5'd9, 32'h90, 32'h91);
        step(0, 1, 5'd11, 32'hB11, 1, 5'd12, 32'hC12, 5'd9, 5'd11, 32'h92, 32'h93);
        step(0, 0, 0, 0, 1, 5'd12, 32'hC12, 5'd11, 5'd12, 32'h94, 32'h95);
        step(0, 0, 0, 0, 0, 0, 0, 5'd12, 5'd11, 32'h96, 32'h97);
        // Randomised traffic; a pending request keeps its sel/data until granted.
        wr = 0; mr = 0; ws = 0; ms = 0; wd = 0; md = 0;
        for (int i = 0; i < 60; i++) begin
            if (!(wr && !eg_wb_last)) begin
                wr = 1'($urandom_range(0, 1));
                ws = rf_addr_t'($urandom_range(0, 7));
                wd = $urandom;
            end
            if (!(mr && !eg_mc_last)) begin
                mr = 1'($urandom_range(0, 1));
                ms = rf_addr_t'($urandom_range(0, 7));
                md = $urandom;
            end
            step(($urandom_range(0, 19) == 0), wr, ws, wd, mr, ms, md,
                 rf_addr_t'($urandom_range(0, 7)), rf_addr_t'($urandom_range(0, 7)),
                 $urandom, $urandom);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
